// File: rtl/dm_cache_pkg.sv
// Shared geometry, bus structs and FSM state type for the direct-mapped cache.
// Tag/data memories are 512 entries of one 256-bit line each.
package cache_def;

    localparam int TAGMSB  = 31;
    localparam int TAGLSB  = 14;
    localparam int INDEX_W = 9;
    localparam int LINE_W  = 256;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAGMSB:TAGLSB] tag;
    } cache_tag_type;

    typedef struct packed {
        logic [INDEX_W-1:0] index;
        logic               we;
    } cache_req_type;

    typedef logic [LINE_W-1:0] cache_data_type;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
        logic        valid;
    } cpu_req_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cpu_result_type;

    typedef struct packed {
        logic [31:0]    addr;
        cache_data_type data;
        logic           rw;
        logic           valid;
    } mem_req_type;

    typedef struct packed {
        cache_data_type data;
        logic           ready;
    } mem_data_type;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE_TAG,
        ALLOCATE,
        WRITE_BACK
    } cache_state_type;

    function automatic logic [31:0] line_word(input cache_data_type line, input logic [2:0] sel);
        return line[{sel, 5'b0} +: 32];
    endfunction

endpackage

// File: rtl/dm_cache_ctrl_word_merge.sv
// Replaces one 32-bit word of a cache line; used to build the write-hit line.
module dm_cache_word_merge
    import cache_def::*;
(
    input  cache_data_type line_i,
    input  logic [2:0]     sel_i,
    input  logic [31:0]    word_i,
    output cache_data_type line_o
);

    // NOTE: assigning the full default first keeps this purely combinational (no latch).
    always_comb begin
        line_o                    = line_i;
        line_o[{sel_i, 5'b0} +: 32] = word_i;
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back / write-allocate cache controller: one CPU request
// at a time, victim write-back then line allocate on a miss.
module dm_cache_ctrl
    import cache_def::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  cpu_req_type    cpu_req,
    output cpu_result_type cpu_res,
    output mem_req_type    mem_req,
    input  mem_data_type   mem_data,
    output cache_req_type  tag_req,
    output cache_tag_type  tag_write,
    input  cache_tag_type  tag_read,
    output cache_req_type  data_req,
    output cache_data_type data_write,
    input  cache_data_type data_read
);

    cache_state_type      state_q;
    logic [31:2]          req_addr_q;
    logic [31:0]          req_data_q;
    logic                 req_rw_q;
    logic [TAGMSB:TAGLSB] victim_tag_q;
    cache_data_type       victim_line_q;
    logic [31:0]          mem_addr_q;
    cache_data_type       mem_line_q;
    logic                 mem_rw_q;

    logic [INDEX_W-1:0]   req_index;
    logic [TAGMSB:TAGLSB] req_tag;
    logic [2:0]           req_sel;
    logic                 hit;
    cache_data_type       merged_line;
    logic                 unused_addr_bits;

    assign req_index        = req_addr_q[TAGLSB-1:5];
    assign req_tag          = req_addr_q[TAGMSB:TAGLSB];
    assign req_sel          = req_addr_q[4:2];
    assign hit              = tag_read.valid && (tag_read.tag == req_tag);
    assign unused_addr_bits = ^cpu_req.addr[1:0];

    dm_cache_word_merge u_merge (
        .line_i (data_read),
        .sel_i  (req_sel),
        .word_i (req_data_q),
        .line_o (merged_line)
    );

    always_comb begin
        cpu_res        = '0;
        tag_req.index  = req_index;
        tag_req.we     = 1'b0;
        data_req.index = req_index;
        data_req.we    = 1'b0;
        tag_write      = '0;
        data_write     = '0;
        // Address/data/rw hold their last driven value between transfers.
        mem_req        = '{addr: mem_addr_q, data: mem_line_q, rw: mem_rw_q, valid: 1'b0};

        case (state_q)
            COMPARE_TAG: begin
                cpu_res.data = line_word(data_read, req_sel);
                if (hit) begin
                    cpu_res.ready = 1'b1;
                    if (req_rw_q) begin
                        data_req.we = 1'b1;
                        data_write  = merged_line;
                        tag_req.we  = 1'b1;
                        tag_write   = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
                    end
                end
            end
            WRITE_BACK: begin
                mem_req = '{addr: {victim_tag_q, req_index, 5'b0}, data: victim_line_q,
                            rw: 1'b1, valid: 1'b1};
            end
            ALLOCATE: begin
                mem_req = '{addr: {req_addr_q[31:5], 5'b0}, data: mem_line_q,
                            rw: 1'b0, valid: 1'b1};
                if (mem_data.ready) begin
                    data_req.we = 1'b1;
                    data_write  = mem_data.data;
                    tag_req.we  = 1'b1;
                    tag_write   = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
                end
            end
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_addr_q    <= '0;
            req_data_q    <= '0;
            req_rw_q      <= 1'b0;
            victim_tag_q  <= '0;
            victim_line_q <= '0;
            mem_addr_q    <= '0;
            mem_line_q    <= '0;
            mem_rw_q      <= 1'b0;
        end else begin
            mem_addr_q <= mem_req.addr;
            mem_line_q <= mem_req.data;
            mem_rw_q   <= mem_req.rw;
            case (state_q)
                IDLE: begin
                    if (cpu_req.valid) begin
                        req_addr_q <= cpu_req.addr[31:2];
                        req_data_q <= cpu_req.data;
                        req_rw_q   <= cpu_req.rw;
                        state_q    <= COMPARE_TAG;
                    end
                end
                COMPARE_TAG: begin
                    if (hit) begin
                        state_q <= IDLE;
                    end else if (tag_read.valid && tag_read.dirty) begin
                        victim_tag_q  <= tag_read.tag;
                        victim_line_q <= data_read;
                        state_q       <= WRITE_BACK;
                    end else begin
                        state_q <= ALLOCATE;
                    end
                end
                WRITE_BACK: if (mem_data.ready) state_q <= ALLOCATE;
                ALLOCATE:   if (mem_data.ready) state_q <= COMPARE_TAG;
                default:    state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench: plays tag/data/main memory, predicts each cycle from a
// transaction-level cache model and compares on the falling edge.
module tb_dm_cache_ctrl;
    import cache_def::*;

    logic           clk;
    logic           rst_n;
    cpu_req_type    cpu_req;
    cpu_result_type cpu_res;
    mem_req_type    mem_req;
    mem_data_type   mem_data;
    cache_req_type  tag_req;
    cache_tag_type  tag_write;
    cache_tag_type  tag_read;
    cache_req_type  data_req;
    cache_data_type data_write;
    cache_data_type data_read;

    dm_cache_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_res    (cpu_res),
        .mem_req    (mem_req),
        .mem_data   (mem_data),
        .tag_req    (tag_req),
        .tag_write  (tag_write),
        .tag_read   (tag_read),
        .data_req   (data_req),
        .data_write (data_write),
        .data_read  (data_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache memories as seen by the DUT: asynchronous read, write on the edge.
    cache_tag_type  tag_mem  [512] = '{default: '0};
    cache_data_type data_mem [512] = '{default: '0};
    assign tag_read  = tag_mem[tag_req.index];
    assign data_read = data_mem[data_req.index];
    always @(posedge clk) begin
        if (tag_req.we)  tag_mem[tag_req.index]   <= tag_write;
        if (data_req.we) data_mem[data_req.index] <= data_write;
    end

    // Reference model: cache contents and main memory.
    cache_tag_type  m_tag  [512] = '{default: '0};
    cache_data_type m_line [512] = '{default: '0};
    cache_data_type main_mem [logic [31:0]];

    typedef struct packed {
        logic           mem_valid;
        logic           mem_rw;
        logic [31:0]    mem_addr;
        cache_data_type mem_wdata;
        logic           drv_ready;
        cache_data_type drv_data;
        logic           cpu_ready;
        logic           chk_data;
        logic [31:0]    cpu_data;
        logic           pulse;
    } cyc_t;

    cyc_t sched [$];
    cyc_t cur;
    logic cur_active = 1'b0;
    int   vectors    = 0;
    int   miscompares = 0;
    int   done;

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cache_data_type init_line(input logic [31:0] la);
        cache_data_type l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = (la | (32'(w) << 2)) ^ 32'h5A00_0000;
        return l;
    endfunction

    function automatic cache_data_type mem_line(input logic [31:0] la);
        return main_mem.exists(la) ? main_mem[la] : init_line(la);
    endfunction

    always @(negedge clk) begin
        if (cur_active) begin
            check("mem_valid", mem_req.valid, cur.mem_valid);
            if (cur.mem_valid) begin
                check("mem_rw", mem_req.rw, cur.mem_rw);
                check("mem_addr", mem_req.addr, cur.mem_addr);
                if (cur.mem_rw) check("mem_wdata", mem_req.data, cur.mem_wdata);
            end
            check("cpu_ready", cpu_res.ready, cur.cpu_ready);
            if (cur.chk_data) check("cpu_data", cpu_res.data, cur.cpu_data);
        end
    end

    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic rw,
                          input int wb_wait, input int alloc_wait, input int pulse_at,
                          output int done_cyc);
        logic [8:0]  idx;
        logic [17:0] tg;
        logic [2:0]  sel;
        logic [31:0] la;
        logic [31:0] va;
        cache_data_type fill;
        cyc_t r;
        idx = a[13:5];
        tg  = a[31:14];
        sel = a[4:2];
        la  = {a[31:5], 5'b0};
        sched.delete();
        r = '0;
        sched.push_back(r);
        if (!(m_tag[idx].valid && m_tag[idx].tag == tg)) begin
            sched.push_back(r);
            if (m_tag[idx].valid && m_tag[idx].dirty) begin
                va = {m_tag[idx].tag, idx, 5'b0};
                main_mem[va] = m_line[idx];
                for (int k = 0; k <= wb_wait; k++) begin
                    r = '0;
                    r.mem_valid = 1'b1; r.mem_rw = 1'b1; r.mem_addr = va;
                    r.mem_wdata = m_line[idx]; r.drv_ready = (k == wb_wait);
                    sched.push_back(r);
                end
            end
            fill = mem_line(la);
            for (int k = 0; k <= alloc_wait; k++) begin
                r = '0;
                r.mem_valid = 1'b1; r.mem_addr = la;
                r.drv_data = fill; r.drv_ready = (k == alloc_wait);
                sched.push_back(r);
            end
            m_line[idx] = fill;
            m_tag[idx]  = '{valid: 1'b1, dirty: 1'b0, tag: tg};
        end
        r = '0;
        r.cpu_ready = 1'b1;
        r.chk_data  = !rw;
        r.cpu_data  = m_line[idx][{sel, 5'b0} +: 32];
        sched.push_back(r);
        done_cyc = sched.size() - 1;
        if (rw) begin
            m_line[idx][{sel, 5'b0} +: 32] = d;
            m_tag[idx].dirty = 1'b1;
        end
        r = '0;
        sched.push_back(r);
        if (pulse_at > 0 && pulse_at < sched.size() - 1) sched[pulse_at].pulse = 1'b1;

        @(posedge clk); #1;
        for (int i = 0; i < sched.size(); i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
                cpu_req = '{addr: 32'hFFFF_FFFC, data: 32'h0BAD_0BAD, rw: 1'b1,
                            valid: sched[i].pulse};
            end else begin
                cpu_req = '{addr: a, data: d, rw: rw, valid: 1'b1};
            end
            mem_data   = '{data: sched[i].drv_data, ready: sched[i].drv_ready};
            cur        = sched[i];
            cur_active = 1'b1;
        end
        @(posedge clk); #1;
        cur_active = 1'b0;
        cpu_req    = '0;
        mem_data   = '0;
    endtask

    initial begin
        rst_n    = 1'b0;
        cpu_req  = '0;
        mem_data = '0;
        #7;
        check("rst_cpu_res", cpu_res, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_tag_req", tag_req, 0);
        check("rst_data_req", data_req, 0);
        check("rst_tag_write", tag_write, 0);
        check("rst_data_write", data_write, 0);
        #5 rst_n = 1'b1;

        // Cold read, 3 wait cycles on allocate.
        do_req(32'h0000_4020, 32'h0, 1'b0, 0, 3, 0, done);
        check("cold_latency", done, 6);
        check("cold_tag", tag_mem[1], 20'h80001);
        check("cold_word0", data_mem[1][31:0], 32'h5A00_4020);

        // Read hit with a spurious pulse during COMPARE_TAG.
        do_req(32'h0000_4024, 32'h0, 1'b0, 0, 0, 1, done);
        check("hit_latency", done, 1);

        // Write hit.
        do_req(32'h0000_4028, 32'hDEAD_BEEF, 1'b1, 0, 0, 0, done);
        check("wr_tag", tag_mem[1], 20'hC0001);
        check("wr_word2", data_mem[1][95:64], 32'hDEAD_BEEF);
        check("wr_word0", data_mem[1][31:0], 32'h5A00_4020);
        check("wr_line", data_mem[1], m_line[1]);

        // Dirty conflict miss: write-back of 0x4020 then allocate 0x8020.
        do_req(32'h0000_8020, 32'h0, 1'b0, 2, 1, 3, done);
        check("dirty_latency", done, 7);
        check("dirty_tag", tag_mem[1], 20'h80002);

        // Clean write miss, memory ready in the first allocate cycle.
        do_req(32'h0000_C044, 32'h1234_5678, 1'b1, 0, 0, 2, done);
        check("wmiss_latency", done, 3);
        check("wmiss_tag", tag_mem[2], 20'hC0003);
        check("wmiss_line", data_mem[2], m_line[2]);

        // Reset while allocate is waiting on memory.
        @(posedge clk); #1;
        cpu_req = '{addr: 32'h0001_0060, data: 32'h0, rw: 1'b0, valid: 1'b1};
        @(posedge clk); #1;
        cpu_req = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_pre_valid", mem_req.valid, 1);
        check("rst_pre_addr", mem_req.addr, 32'h0001_0060);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", mem_req.valid, 0);
        check("rst_mid_ready", cpu_res.ready, 0);
        check("rst_mid_twe", tag_req.we, 0);
        check("rst_mid_dwe", data_req.we, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_idle_valid", mem_req.valid, 0);
        check("rst_tag_kept", tag_mem[3], 20'h0);

        // Same line again, now to completion, with a busy-time pulse.
        do_req(32'h0001_0060, 32'h0, 1'b0, 0, 2, 2, done);
        check("retry_tag", tag_mem[3], 20'h80004);

        // Hit on the line brought in by the conflict miss.
        do_req(32'h0000_8024, 32'h0, 1'b0, 0, 0, 1, done);

        // Clean miss back to 0x4028: must return the written-back word.
        do_req(32'h0000_4028, 32'h0, 1'b0, 0, 0, 0, done);
        check("wb_roundtrip", data_mem[1][95:64], 32'hDEAD_BEEF);

        // Dirty miss with memory ready immediately on write-back and allocate.
        do_req(32'h0000_0040, 32'h0, 1'b0, 0, 0, 0, done);
        check("fast_dirty_latency", done, 4);
        check("fast_dirty_tag", tag_mem[2], 20'h80000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
